// File: rtl/cacheline_mem_arbiter_pkg.sv
// Shared types for the cacheline memory arbiter: FSM states, port ids and line geometry.
package cache_pkg;

  localparam int LINE_WIDTH       = 256;
  localparam int LINE_OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } port_id_t;

endpackage

// File: rtl/cacheline_mem_arbiter.sv
// Shares one cacheline memory port between icache and dcache with 2-way round-robin.
// One transaction in flight; downstream strobes are registered, responses route combinationally.
module cacheline_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_read,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);
  import cache_pkg::arb_state_t;
  import cache_pkg::port_id_t;
  import cache_pkg::IDLE;
  import cache_pkg::BUSY_I;
  import cache_pkg::BUSY_D;
  import cache_pkg::ICACHE;
  import cache_pkg::DCACHE;

  localparam int                    OFFSET_W    = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_W) - 1);

  arb_state_t state, state_nxt;
  port_id_t   last_grant, grant_port;
  logic       grant;
  logic       d_req;

  assign d_req = d_read | d_write;

  // Next-state and grant pick; ties go to the port that did not win last.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_port = ICACHE;
    case (state)
      IDLE: begin
        if (i_read || d_req) begin
          grant = 1'b1;
          if (i_read && (!d_req || last_grant == DCACHE)) grant_port = ICACHE;
          else                                           grant_port = DCACHE;
          state_nxt = (grant_port == ICACHE) ? BUSY_I : BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Downstream request is latched at grant and held frozen until mem_resp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= DCACHE;
      mem_addr   <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last_grant <= grant_port;
        if (grant_port == ICACHE) begin
          mem_addr  <= i_addr & ~OFFSET_MASK;
          mem_read  <= 1'b1;
          mem_write <= 1'b0;
          mem_wdata <= '0;
        end else begin
          // read+write together is resolved as a write-back
          mem_addr  <= d_addr & ~OFFSET_MASK;
          mem_read  <= ~d_write;
          mem_write <= d_write;
          mem_wdata <= d_wdata;
        end
      end else if (state != IDLE && mem_resp) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
    end
  end

  // Response routing; mem_resp outside a transaction is dropped.
  always_comb begin
    i_resp  = mem_resp && (state == BUSY_I);
    d_resp  = mem_resp && (state == BUSY_D);
    i_rdata = '0;
    d_rdata = '0;
    if (i_resp) i_rdata = mem_rdata;
    if (d_resp) d_rdata = mem_rdata;
  end

`ifndef SYNTHESIS
  rw_exclusive: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));
`endif

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a transaction-level model.
module tb_cacheline_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr, d_addr, mem_addr;
  logic         i_read, d_read, d_write;
  logic [255:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic         i_resp, d_resp, mem_read, mem_write, mem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  cacheline_mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    logic [255:0] pat, rd;
    pat = rand_line();
    rd  = rand_line();
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    #2 rst = 1'b0;
    d_write = 1'b1; d_addr = 32'h1234_5677; d_wdata = pat;
    step(); step();
    n_checks++;
    if ({mem_read, mem_write, mem_addr, mem_wdata, i_resp, i_rdata, d_resp, d_rdata} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: rd=%b wr=%b addr=%h ir=%b dr=%b, all required 0",
                               mem_read, mem_write, mem_addr, i_resp, d_resp); end
    rst = 1'b1;
    step();
    n_checks++;
    if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 32'h1234_5660 || mem_wdata !== pat)
      begin n_fail++; $display("FAIL reset_release_write: rd=%b wr=%b addr=%h, required rd=0 wr=1 addr=12345660",
                               mem_read, mem_write, mem_addr); end
    mem_resp = 1'b1; mem_rdata = rd;
    #1;
    n_checks++;
    if (d_resp !== 1'b1 || d_rdata !== rd || i_resp !== 1'b0)
      begin n_fail++; $display("FAIL reset_release_resp: d_resp=%b i_resp=%b, required 1/0", d_resp, i_resp); end
    step();
    mem_resp = 1'b0; d_write = 1'b0;
    n_checks++;
    if ({mem_read, mem_write} !== 2'b00)
      begin n_fail++; $display("FAIL reset_release_clear: rd=%b wr=%b, required 0 0", mem_read, mem_write); end
  endtask

  task automatic test_icache_alone();
    logic [255:0] rd;
    rd = {8{32'hA5A5_A5A5}};
    i_read = 1'b1; i_addr = 32'h0000_1234;
    step();
    n_checks++;
    if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 32'h0000_1220)
      begin n_fail++; $display("FAIL icache_grant: rd=%b wr=%b addr=%h, required 1 0 00001220",
                               mem_read, mem_write, mem_addr); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (mem_read !== 1'b1 || i_resp !== 1'b0)
        begin n_fail++; $display("FAIL icache_wait: cyc=%0d rd=%b i_resp=%b, required 1 0", k, mem_read, i_resp); end
    end
    mem_resp = 1'b1; mem_rdata = rd;
    #1;
    n_checks++;
    if (i_resp !== 1'b1 || i_rdata !== rd || d_resp !== 1'b0 || d_rdata !== '0)
      begin n_fail++; $display("FAIL icache_resp: i_resp=%b d_resp=%b i_rdata=%h, required 1 0 a5..a5",
                               i_resp, d_resp, i_rdata); end
    step();
    mem_resp = 1'b0; i_read = 1'b0;
    n_checks++;
    if (mem_read !== 1'b0 || i_resp !== 1'b0 || i_rdata !== '0)
      begin n_fail++; $display("FAIL icache_done: rd=%b i_resp=%b, required 0 0", mem_read, i_resp); end
  endtask

  task automatic test_tie_alternation();
    logic [255:0] rd;
    int lat;
    rst = 1'b0; step(); rst = 1'b1;
    i_addr = 32'h0000_1040; d_addr = 32'h0000_2080;
    i_read = 1'b1; d_read = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step();
      n_checks++;
      if ({mem_read, mem_write} !== 2'b10 ||
          mem_addr !== ((t % 2 == 0) ? 32'h0000_1040 : 32'h0000_2080))
        begin n_fail++; $display("FAIL tie_order: txn=%0d rd=%b addr=%h, required owner %s",
                                 t, mem_read, mem_addr, (t % 2 == 0) ? "I" : "D"); end
      lat = $urandom_range(0, 3);
      repeat (lat) step();
      rd = rand_line();
      mem_resp = 1'b1; mem_rdata = rd;
      #1;
      n_checks++;
      if (i_resp !== (t % 2 == 0) || d_resp !== (t % 2 == 1))
        begin n_fail++; $display("FAIL tie_resp: txn=%0d i_resp=%b d_resp=%b", t, i_resp, d_resp); end
      step();
      mem_resp = 1'b0;
      if (t == 3) begin i_read = 1'b0; d_read = 1'b0; end
      n_checks++;
      if ({mem_read, mem_write} !== 2'b00)
        begin n_fail++; $display("FAIL tie_gap: txn=%0d rd=%b wr=%b, required 0 0", t, mem_read, mem_write); end
    end
  endtask

  task automatic test_dcache_write();
    logic [255:0] pat, rd;
    pat = rand_line();
    rd  = rand_line();
    d_write = 1'b1; d_addr = 32'h8000_01E0; d_wdata = pat;
    step();
    n_checks++;
    if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 32'h8000_01E0 || mem_wdata !== pat)
      begin n_fail++; $display("FAIL dwrite_grant: rd=%b wr=%b addr=%h, required 0 1 800001e0",
                               mem_read, mem_write, mem_addr); end
    for (int k = 0; k < 3; k++) begin
      d_addr = $urandom; d_wdata = rand_line();
      step();
      n_checks++;
      if (mem_write !== 1'b1 || mem_addr !== 32'h8000_01E0 || mem_wdata !== pat)
        begin n_fail++; $display("FAIL dwrite_frozen: cyc=%0d wr=%b addr=%h, required 1 800001e0",
                                 k, mem_write, mem_addr); end
    end
    mem_resp = 1'b1; mem_rdata = rd;
    #1;
    n_checks++;
    if (d_resp !== 1'b1 || d_rdata !== rd || i_resp !== 1'b0)
      begin n_fail++; $display("FAIL dwrite_resp: d_resp=%b i_resp=%b, required 1 0", d_resp, i_resp); end
    step();
    mem_resp = 1'b0; d_write = 1'b0;
    n_checks++;
    if (mem_write !== 1'b0)
      begin n_fail++; $display("FAIL dwrite_done: wr=%b, required 0", mem_write); end
  endtask

  task automatic test_spurious();
    mem_resp = 1'b1; mem_rdata = rand_line();
    #1;
    n_checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== '0 || d_rdata !== '0)
      begin n_fail++; $display("FAIL spurious_resp: i_resp=%b d_resp=%b, required 0 0", i_resp, d_resp); end
    step();
    mem_resp = 1'b0;
    n_checks++;
    if ({mem_read, mem_write} !== 2'b00)
      begin n_fail++; $display("FAIL spurious_state: rd=%b wr=%b, required 0 0", mem_read, mem_write); end
    i_read = 1'b1; i_addr = 32'h0000_0040;
    step();
    n_checks++;
    if (mem_read !== 1'b1 || mem_addr !== 32'h0000_0040)
      begin n_fail++; $display("FAIL spurious_regrant: rd=%b addr=%h, required 1 00000040", mem_read, mem_addr); end
    mem_resp = 1'b1;
    #1;
    n_checks++;
    if (i_resp !== 1'b1)
      begin n_fail++; $display("FAIL spurious_complete: i_resp=%b, required 1", i_resp); end
    step();
    mem_resp = 1'b0; i_read = 1'b0;
  endtask

  task automatic test_abort();
    logic [255:0] rd;
    rd = rand_line();
    i_read = 1'b1; i_addr = 32'h0000_0ABC;
    step();
    n_checks++;
    if (mem_read !== 1'b1 || mem_addr !== 32'h0000_0AA0)
      begin n_fail++; $display("FAIL abort_grant: rd=%b addr=%h, required 1 00000aa0", mem_read, mem_addr); end
    i_read = 1'b0;
    step(); step();
    n_checks++;
    if (mem_read !== 1'b1)
      begin n_fail++; $display("FAIL abort_held: rd=%b, required 1", mem_read); end
    mem_resp = 1'b1; mem_rdata = rd;
    #1;
    n_checks++;
    if (i_resp !== 1'b1 || i_rdata !== rd)
      begin n_fail++; $display("FAIL abort_resp: i_resp=%b, required 1 with data", i_resp); end
    step();
    mem_resp = 1'b0;
    n_checks++;
    if (mem_read !== 1'b0 || i_resp !== 1'b0)
      begin n_fail++; $display("FAIL abort_done: rd=%b i_resp=%b, required 0 0", mem_read, i_resp); end
  endtask

  task automatic test_reset_mid();
    d_write = 1'b1; d_addr = 32'h0000_3000; d_wdata = rand_line();
    step();
    n_checks++;
    if (mem_write !== 1'b1)
      begin n_fail++; $display("FAIL rstmid_busy: wr=%b, required 1", mem_write); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({mem_read, mem_write} !== 2'b00)
      begin n_fail++; $display("FAIL rstmid_async: rd=%b wr=%b, required 0 0", mem_read, mem_write); end
    d_write = 1'b0;
    step();
    rst = 1'b1;
    i_addr = 32'h0000_5000; d_addr = 32'h0000_6000;
    i_read = 1'b1; d_read = 1'b1;
    step();
    n_checks++;
    if (mem_read !== 1'b1 || mem_addr !== 32'h0000_5000)
      begin n_fail++; $display("FAIL rstmid_tie: rd=%b addr=%h, required 1 00005000", mem_read, mem_addr); end
    mem_resp = 1'b1;
    #1;
    n_checks++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_resp: i_resp=%b d_resp=%b, required 1 0", i_resp, d_resp); end
    step();
    mem_resp = 1'b0; i_read = 1'b0;
    step();
    n_checks++;
    if (mem_read !== 1'b1 || mem_addr !== 32'h0000_6000)
      begin n_fail++; $display("FAIL rstmid_second: rd=%b addr=%h, required 1 00006000", mem_read, mem_addr); end
    mem_resp = 1'b1;
    #1;
    n_checks++;
    if (d_resp !== 1'b1)
      begin n_fail++; $display("FAIL rstmid_dresp: d_resp=%b, required 1", d_resp); end
    step();
    mem_resp = 1'b0; d_read = 1'b0;
  endtask

  // Transaction-level model: one outstanding line op, ties alternate, strobe one cycle after grant.
  task automatic test_random();
    logic         busy, pend, resp_now, i_done, d_done, g_wr, p_wr, i_fly, d_fly;
    int           owner, p_owner, last, lat;
    logic [31:0]  g_addr, p_addr;
    logic [255:0] g_wdata, p_wdata, rd;
    logic         exp_i, exp_d;
    rst = 1'b0; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    step();
    rst = 1'b1;
    busy = 0; pend = 0; i_done = 0; d_done = 0; last = 1; owner = 0; p_owner = 0; lat = 0;
    g_wr = 0; p_wr = 0; g_addr = 0; p_addr = 0; g_wdata = 0; p_wdata = 0;
    for (int c = 0; c < 3000; c++) begin
      if (pend) begin
        busy = 1; owner = p_owner; g_addr = p_addr; g_wr = p_wr; g_wdata = p_wdata;
        lat = $urandom_range(0, 4); pend = 0;
      end
      n_checks++;
      if (busy) begin
        if ({mem_read, mem_write} !== (g_wr ? 2'b01 : 2'b10) || mem_addr !== g_addr ||
            (g_wr && mem_wdata !== g_wdata))
          begin n_fail++; $display("FAIL rand_strobe: cyc=%0d rd=%b wr=%b addr=%h, required wr=%b addr=%h",
                                   c, mem_read, mem_write, mem_addr, g_wr, g_addr); end
      end else if ({mem_read, mem_write} !== 2'b00)
        begin n_fail++; $display("FAIL rand_idle: cyc=%0d rd=%b wr=%b, required 0 0", c, mem_read, mem_write); end

      resp_now = 1'b0;
      if (busy) begin
        if (lat == 0) resp_now = 1'b1;
        else lat--;
      end
      rd = rand_line();
      mem_rdata = rd;
      mem_resp = resp_now || (!busy && $urandom_range(0, 7) == 0);

      i_fly = (busy && owner == 0) || (pend && p_owner == 0);
      d_fly = (busy && owner == 1) || (pend && p_owner == 1);
      if (i_done) begin i_read = 1'b0; i_done = 1'b0; end
      if (!i_read && !i_fly && $urandom_range(0, 2) == 0) begin
        i_read = 1'b1; i_addr = $urandom;
      end else if (i_read && i_fly) begin
        i_addr = $urandom;
        if ($urandom_range(0, 7) == 0) i_read = 1'b0;
      end
      if (d_done) begin d_read = 1'b0; d_write = 1'b0; d_done = 1'b0; end
      if (!d_read && !d_write && !d_fly && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) d_read = 1'b1; else d_write = 1'b1;
        d_addr = $urandom; d_wdata = rand_line();
      end else if ((d_read || d_write) && d_fly) begin
        d_addr = $urandom; d_wdata = rand_line();
      end

      #1;
      exp_i = resp_now && owner == 0;
      exp_d = resp_now && owner == 1;
      n_checks++;
      if (i_resp !== exp_i || d_resp !== exp_d)
        begin n_fail++; $display("FAIL rand_resp: cyc=%0d i_resp=%b d_resp=%b, required %b %b",
                                 c, i_resp, d_resp, exp_i, exp_d); end
      n_checks++;
      if (i_rdata !== (exp_i ? rd : 256'd0) || d_rdata !== (exp_d ? rd : 256'd0))
        begin n_fail++; $display("FAIL rand_rdata: cyc=%0d i_rdata=%h d_rdata=%h", c, i_rdata, d_rdata); end

      if (resp_now) begin
        if (owner == 0) i_done = 1'b1; else d_done = 1'b1;
      end
      if (!busy && (i_read || d_read || d_write)) begin
        if (i_read && (d_read || d_write)) p_owner = (last == 0) ? 1 : 0;
        else                               p_owner = i_read ? 0 : 1;
        last    = p_owner;
        pend    = 1'b1;
        p_addr  = ((p_owner == 0) ? i_addr : d_addr) & 32'hFFFF_FFE0;
        p_wr    = (p_owner == 1) && d_write;
        p_wdata = d_wdata;
      end
      if (resp_now) busy = 1'b0;
      step();
    end
    mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_icache_alone();
    test_tie_alternation();
    test_dcache_write();
    test_spurious();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
